// File: rtl/riscof_ctrl_responder.sv
// Memory-mapped test-control responder: HALT, signature bounds, cycle counter and status.
// Optional watchdog enabled by defining RISCOF_CTRL_WATCHDOG_EN.
module riscof_ctrl_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    LATENCY    = 1,
  parameter int                    TIMEOUT    = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  wvalid_o,
  output logic                  err_o,
  output logic                  halt_o,
  output logic [ADDR_WIDTH-1:0] sig_start_o,
  output logic [ADDR_WIDTH-1:0] sig_end_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_wcnt;
  logic [3:0]            r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_sig_start;
  logic [DATA_WIDTH-1:0] r_sig_end;
  logic [31:0]           r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_wvalid;
  logic                  r_err;
  logic                  r_halt;
  logic                  r_halt_set;
  logic                  r_viol;

  logic [ADDR_WIDTH-1:0] w_off;
  logic [2:0]            w_idx;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_ss_new;
  logic [DATA_WIDTH-1:0] w_se_new;
  logic                  w_to;
  logic                  w_wd_hit;

  // Addresses below the base wrap to a large offset, so one compare covers both bounds.
  assign w_off = r_addr - BASE_ADDR;
  assign w_idx = w_off[4:2];
  assign w_err = (r_addr[1:0] != 2'b00) || (w_off >= ADDR_WIDTH'(32));

`ifdef RISCOF_CTRL_WATCHDOG_EN
  logic r_to;
  assign w_wd_hit = !r_halt && (r_cnt == 32'(TIMEOUT));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         r_to <= 1'b0;
    else if (w_wd_hit) r_to <= 1'b1;
  end
  assign w_to = r_to;
`else
  assign w_wd_hit = 1'b0;
  assign w_to     = 1'b0;
`endif

  always_comb begin
    w_ss_new = r_sig_start;
    w_se_new = r_sig_end;
    for (int unsigned b = 0; b < 4; b++) begin
      if (r_we[b]) begin
        w_ss_new[8*b +: 8] = r_wdata[8*b +: 8];
        w_se_new[8*b +: 8] = r_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (w_idx)
      3'd0:    w_rd = DATA_WIDTH'(r_halt);
      3'd1:    w_rd = r_sig_start;
      3'd2:    w_rd = r_sig_end;
      3'd3:    w_rd = DATA_WIDTH'(r_cnt);
      3'd4:    w_rd = DATA_WIDTH'({w_to, r_viol, r_halt});
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_i) w_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (r_wcnt == 4'd1) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wcnt      <= '0;
      r_we        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sig_start <= '0;
      r_sig_end   <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_wvalid    <= 1'b0;
      r_err       <= 1'b0;
      r_halt      <= 1'b0;
      r_halt_set  <= 1'b0;
      r_viol      <= 1'b0;
    end else begin
      r_rvalid   <= 1'b0;
      r_wvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_halt_set <= 1'b0;
      if (!r_halt && !w_wd_hit) r_cnt <= r_cnt + 32'd1;
      // HALT write lands one cycle after its response pulse.
      r_halt <= r_halt | r_halt_set | w_wd_hit;
      if (req_i && (r_state != IDLE)) r_viol <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_wcnt  <= 4'(LATENCY - 1);
          end
        end
        WAIT: r_wcnt <= r_wcnt - 4'd1;
        RESP: begin
          if (w_err) begin
            r_err <= 1'b1;
          end else if (r_we == 4'd0) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd;
          end else begin
            r_wvalid <= 1'b1;
            unique case (w_idx)
              3'd0:    r_halt_set  <= r_we[0] & r_wdata[0];
              3'd1:    r_sig_start <= w_ss_new;
              3'd2:    r_sig_end   <= w_se_new;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata_o     = r_rdata;
  assign rvalid_o    = r_rvalid;
  assign wvalid_o    = r_wvalid;
  assign err_o       = r_err;
  assign halt_o      = r_halt;
  assign sig_start_o = ADDR_WIDTH'(r_sig_start);
  assign sig_end_o   = ADDR_WIDTH'(r_sig_end);

endmodule

// File: tb/tb_riscof_ctrl_responder.sv
// Scoreboard bench for riscof_ctrl_responder: LATENCY=1 and LATENCY=4 instances.
// Watchdog scenario expectations follow RISCOF_CTRL_WATCHDOG_EN.
module tb_riscof_ctrl_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          TO   = 100;
  localparam int          NONE = 32'h7fff_ffff;

  typedef struct {
    logic [2:0]  kind;   // {rvalid, wvalid, err}
    logic [31:0] data;
    logic [31:0] ss;
    logic [31:0] se;
    int          cyc;
  } exp_t;

  logic        clk, rst, req1, req4;
  logic [3:0]  we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata1, rdata4, ss1, ss4, se1, se4;
  logic        rv1, wv1, er1, h1, rv4, wv4, er4, h4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t        q1[$];
  exp_t        q4[$];
  logic [31:0] m_ss[2], m_se[2], m_last[2], last_rd[2];
  int          m_hvis[2], m_freeze[2];
  logic        m_viol[2], m_to[2];
  int          m_rel;

  riscof_ctrl_responder #(.LATENCY(1), .TIMEOUT(TO)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata1), .rvalid_o(rv1), .wvalid_o(wv1), .err_o(er1), .halt_o(h1),
    .sig_start_o(ss1), .sig_end_o(se1));

  riscof_ctrl_responder #(.LATENCY(4), .TIMEOUT(TO)) u4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata4), .rvalid_o(rv4), .wvalid_o(wv4), .err_o(er4), .halt_o(h4),
    .sig_start_o(ss4), .sig_end_o(se4));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Scoreboard pop/compare on every response pulse.
  task automatic chk_resp(input int sel);
    logic [2:0]  k;
    logic [31:0] rd, ss, se;
    exp_t        e;
    k  = sel ? {rv4, wv4, er4} : {rv1, wv1, er1};
    rd = sel ? rdata4 : rdata1;
    ss = sel ? ss4 : ss1;
    se = sel ? se4 : se1;
    if (k != 3'b000) begin
      if ((sel ? q4.size() : q1.size()) == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp inst%0d cyc %0d pulses %b want none", sel, cyc, k);
      end else begin
        e = sel ? q4.pop_front() : q1.pop_front();
        checks++;
        if (k !== e.kind || cyc !== e.cyc) begin
          errors++;
          $display("FAIL resp_kind inst%0d got %b at cyc %0d want %b at cyc %0d", sel, k, cyc, e.kind, e.cyc);
        end
        checks++;
        if (rd !== e.data) begin
          errors++;
          $display("FAIL rdata inst%0d got %h want %h", sel, rd, e.data);
        end
        checks++;
        if ({ss, se} !== {e.ss, e.se}) begin
          errors++;
          $display("FAIL sig_regs inst%0d got %h/%h want %h/%h", sel, ss, se, e.ss, e.se);
        end
        if (k == 3'b100) last_rd[sel] = rd;
      end
    end
  endtask

  always @(negedge clk) begin
    chk_resp(0);
    chk_resp(1);
  end

  task automatic drive_req(input int sel, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    we = w; addr = a; wdata = d;
    if (sel == 0) req1 = 1'b1; else req4 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0; req4 = 1'b0;
  endtask

  // Computes the expected response from the register model, pushes it, then drives.
  task automatic bus(input int sel, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    int          lat, j, mn;
    logic [31:0] off, v;
    logic        hb;
    lat = sel ? 4 : 1;
    j   = cyc;
    off = a - BASE;
    hb  = (j + lat + 1) > m_hvis[sel];
    mn  = (j + lat < m_freeze[sel]) ? j + lat : m_freeze[sel];
    e.cyc = j + lat + 1;
    if (a[1:0] != 2'b00 || a < BASE || off >= 32) begin
      e.kind = 3'b001; e.data = m_last[sel];
    end else if (w == 4'd0) begin
      case (off[4:2])
        3'd0:    v = {31'd0, hb};
        3'd1:    v = m_ss[sel];
        3'd2:    v = m_se[sel];
        3'd3:    v = 32'(mn - m_rel);
        3'd4:    v = {29'd0, m_to[sel] & hb, m_viol[sel], hb};
        default: v = 32'd0;
      endcase
      m_last[sel] = v;
      e.kind = 3'b100; e.data = v;
    end else begin
      e.kind = 3'b010; e.data = m_last[sel];
      case (off[4:2])
        3'd0: if (w[0] && d[0] && (j + lat + 2 < m_hvis[sel])) begin
          m_hvis[sel] = j + lat + 2; m_freeze[sel] = j + lat + 2; m_to[sel] = 1'b0;
        end
        3'd1: m_ss[sel] = merge(m_ss[sel], d, w);
        3'd2: m_se[sel] = merge(m_se[sel], d, w);
        default: ;
      endcase
    end
    e.ss = m_ss[sel]; e.se = m_se[sel];
    if (sel == 0) q1.push_back(e); else q4.push_back(e);
    drive_req(sel, w, a, d);
  endtask

  task automatic drop(input int sel);
    m_viol[sel] = 1'b1;
    drive_req(sel, 4'h0, BASE, 32'd0);
  endtask

  task automatic wait_resp(input int sel);
    for (int i = 0; i < 40 && (sel ? q4.size() : q1.size()) > 0; i++) @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if ((sel ? q4.size() : q1.size()) != 0) begin
      errors++;
      $display("FAIL resp_timeout inst%0d pending %0d want 0", sel, sel ? q4.size() : q1.size());
      q1.delete(); q4.delete();
    end
  endtask

  task automatic rst_release;
    rst = 1'b0;
    m_rel = cyc;
    for (int s = 0; s < 2; s++) begin
      m_ss[s] = '0; m_se[s] = '0; m_last[s] = '0; m_viol[s] = 1'b0;
`ifdef RISCOF_CTRL_WATCHDOG_EN
      m_hvis[s] = m_rel + TO + 1; m_freeze[s] = m_rel + TO; m_to[s] = 1'b1;
`else
      m_hvis[s] = NONE; m_freeze[s] = NONE; m_to[s] = 1'b0;
`endif
    end
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1; q1.delete(); q4.delete();
    repeat (3) @(posedge clk);
    #1 rst_release();
  endtask

  task automatic test_reset;
    rst = 1'b1; req1 = 1'b0; req4 = 1'b0; we = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdata1, rv1, wv1, er1, h1, ss1, se1} !== '0) begin
      errors++; $display("FAIL reset_u1 got %h want 0", {rdata1, rv1, wv1, er1, h1, ss1, se1});
    end
    checks++;
    if ({rdata4, rv4, wv4, er4, h4, ss4, se4} !== '0) begin
      errors++; $display("FAIL reset_u4 got %h want 0", {rdata4, rv4, wv4, er4, h4, ss4, se4});
    end
    rst_release();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rdata1, rv1, wv1, er1, h1, ss1, se1} !== '0) begin
      errors++; $display("FAIL post_reset_u1 got %h want 0", {rdata1, rv1, wv1, er1, h1, ss1, se1});
    end
  endtask

  task automatic test_sig_rw;
    bus(0, 4'hF, BASE + 32'h04, 32'h8000_2000); wait_resp(0);
    bus(0, 4'h0, BASE + 32'h04, 32'd0);         wait_resp(0);
    checks++;
    if (ss1 !== 32'h8000_2000) begin
      errors++; $display("FAIL sig_start_o got %h want 80002000", ss1);
    end
    bus(0, 4'h0, BASE + 32'h0C, 32'd0);         wait_resp(0);
    bus(0, 4'hF, BASE + 32'h0C, 32'h1234_5678); wait_resp(0);
    bus(0, 4'hF, BASE + 32'h18, 32'hFFFF_FFFF); wait_resp(0);
    bus(0, 4'h0, BASE + 32'h18, 32'd0);         wait_resp(0);
    bus(0, 4'h0, BASE + 32'h0C, 32'd0);         wait_resp(0);
  endtask

  task automatic test_byte_write;
    bus(0, 4'hF, BASE + 32'h08, 32'h1122_3344); wait_resp(0);
    bus(0, 4'h2, BASE + 32'h08, 32'h0000_AA00); wait_resp(0);
    bus(0, 4'h0, BASE + 32'h08, 32'd0);         wait_resp(0);
    checks++;
    if (last_rd[0] !== 32'h1122_AA44) begin
      errors++; $display("FAIL byte_write got %h want 1122aa44", last_rd[0]);
    end
    bus(0, 4'h9, BASE + 32'h04, 32'hDD00_00EE); wait_resp(0);
  endtask

  task automatic test_errors;
    bus(0, 4'h0, BASE + 32'h06, 32'd0);         wait_resp(0);
    bus(0, 4'h0, BASE + 32'h40, 32'd0);         wait_resp(0);
    bus(0, 4'hF, BASE - 32'h04, 32'hFFFF_FFFF); wait_resp(0);
    bus(0, 4'hF, BASE + 32'h21, 32'hFFFF_FFFF); wait_resp(0);
    bus(0, 4'h0, BASE + 32'h04, 32'd0);         wait_resp(0);
  endtask

  task automatic test_back_to_back;
    bus(0, 4'hF, BASE + 32'h08, 32'h0BAD_F00D);
    drop(0);
    wait_resp(0);
    bus(0, 4'hF, BASE + 32'h04, 32'h0000_1000);
    @(posedge clk); #1;
    bus(0, 4'h0, BASE + 32'h04, 32'd0);
    wait_resp(0);
    bus(0, 4'h0, BASE + 32'h10, 32'd0); wait_resp(0);
  endtask

  task automatic test_latency4;
    bus(1, 4'hF, BASE + 32'h04, 32'hCAFE_0004);
    @(posedge clk); #1;
    drop(1);
    wait_resp(1);
    repeat (8) begin
      @(negedge clk);
      checks++;
      if ({rv4, wv4, er4} !== 3'b000) begin
        errors++; $display("FAIL l4_extra_resp got %b want 000", {rv4, wv4, er4});
      end
    end
    @(posedge clk); #1;
    bus(1, 4'h0, BASE + 32'h10, 32'd0); wait_resp(1);
    bus(1, 4'h0, BASE + 32'h04, 32'd0); wait_resp(1);
  endtask

  task automatic test_halt;
    logic [31:0] c0;
    bus(0, 4'h0, BASE + 32'h0C, 32'd0); wait_resp(0);
    bus(0, 4'hF, BASE + 32'h00, 32'h0000_0001);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (h1 !== (cyc >= m_hvis[0])) begin
        errors++; $display("FAIL halt_timing cyc %0d got %b want %b", cyc, h1, cyc >= m_hvis[0]);
      end
    end
    wait_resp(0);
    bus(0, 4'h0, BASE + 32'h0C, 32'd0); wait_resp(0);
    c0 = last_rd[0];
    repeat (10) @(posedge clk);
    #1;
    bus(0, 4'h0, BASE + 32'h0C, 32'd0); wait_resp(0);
    checks++;
    if (last_rd[0] !== c0) begin
      errors++; $display("FAIL cnt_frozen got %h want %h", last_rd[0], c0);
    end
    bus(0, 4'hF, BASE + 32'h00, 32'd0);         wait_resp(0);
    bus(0, 4'hF, BASE + 32'h08, 32'h5555_AAAA); wait_resp(0);
    bus(0, 4'h0, BASE + 32'h10, 32'd0);         wait_resp(0);
    bus(0, 4'h0, BASE + 32'h00, 32'd0);         wait_resp(0);
  endtask

  task automatic test_watchdog;
    logic [31:0] want;
    do_reset();
    repeat (TO + 20) @(posedge clk);
    #1;
    checks++;
    if (h1 !== (cyc >= m_hvis[0])) begin
      errors++; $display("FAIL wd_halt got %b want %b", h1, cyc >= m_hvis[0]);
    end
`ifdef RISCOF_CTRL_WATCHDOG_EN
    want = 32'h5;
`else
    want = 32'h0;
`endif
    bus(0, 4'h0, BASE + 32'h10, 32'd0); wait_resp(0);
    checks++;
    if (last_rd[0] !== want) begin
      errors++; $display("FAIL wd_status got %h want %h", last_rd[0], want);
    end
    bus(0, 4'h0, BASE + 32'h0C, 32'd0); wait_resp(0);
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    drive_req(1, 4'hF, BASE + 32'h04, 32'h7777_7777);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({rdata4, rv4, wv4, er4, h4, ss4, se4} !== '0) begin
      errors++; $display("FAIL midrst_u4 got %h want 0", {rdata4, rv4, wv4, er4, h4, ss4, se4});
    end
    checks++;
    if ({rdata1, rv1, wv1, er1, h1, ss1, se1} !== '0) begin
      errors++; $display("FAIL midrst_u1 got %h want 0", {rdata1, rv1, wv1, er1, h1, ss1, se1});
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++;
      if ({rv4, wv4, er4} !== 3'b000) begin
        errors++; $display("FAIL midrst_pulse cyc %0d got %b want 000", cyc, {rv4, wv4, er4});
      end
      if (i == 5) begin
        @(posedge clk); #1 rst_release();
      end
    end
    @(posedge clk); #1;
    bus(1, 4'h0, BASE + 32'h04, 32'd0); wait_resp(1);
    bus(1, 4'h0, BASE + 32'h10, 32'd0); wait_resp(1);
  endtask

  initial begin
    test_reset();
    test_sig_rw();
    test_byte_write();
    test_errors();
    test_back_to_back();
    test_latency4();
    do_reset();
    test_halt();
    test_watchdog();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
